// File: rtl/pc_next_unit.sv
// pc_next_unit: fetch PC register with prioritised trap/jump/branch redirect and stall-time redirect buffering.
module pc_next_unit #(
    parameter int WIDTH = 32,
    parameter int INC = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(32'h0000_0100)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             trap,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic             inst_ce,
    output logic             redirect_pending
);
    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN = 1'b1;
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
    localparam logic [WIDTH-1:0] ALIGN = ~(INC_W - WIDTH'(1));
    logic [0:0] state;
    logic [1:0] req_kind, pend_kind;
    logic [WIDTH-1:0] req_tgt, pend_tgt;
    logic take_new;
    // kind encodes priority directly: 3 trap, 2 jump, 1 branch, 0 none
    always_comb begin
        req_kind = trap ? 2'd3 : jump ? 2'd2 : branch_taken ? 2'd1 : 2'd0;
        req_tgt = (trap ? TRAP_VECTOR : jump ? jump_target : branch_target) & ALIGN;
        take_new = (req_kind != 2'd0) && (!redirect_pending || req_kind >= pend_kind);
    end
    assign pc_plus_inc = pc + INC_W;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
            pc <= RESET_VECTOR;
            inst_ce <= 1'b0;
            redirect_pending <= 1'b0;
            pend_kind <= 2'd0;
            pend_tgt <= '0;
        end else if (state == BOOT) begin
            state <= RUN;
            inst_ce <= 1'b1;
        end else if (stall) begin
            if (take_new) begin
                pend_kind <= req_kind;
                pend_tgt <= req_tgt;
                redirect_pending <= 1'b1;
            end
        end else begin
            pc <= take_new ? req_tgt : redirect_pending ? pend_tgt : pc_plus_inc;
            redirect_pending <= 1'b0;
            pend_kind <= 2'd0;
        end
    end
endmodule
